// File: rtl/bp_pkg.sv
// Shared branch-predictor types and default sizes for the global-history controller.
package bp_pkg;

    localparam int GHR_W_DEF      = 10;
    localparam int CKPT_DEPTH_DEF = 4;

    typedef logic [GHR_W_DEF-1:0] ghr_t;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// One-bit-wide FIFO holding the predicted direction of each in-flight branch.
// The caller guarantees push is never asserted when full without a pop, and pop never when empty.
module ghr_ckpt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic                       din,
    output logic                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DEPTH-1:0]           q_bits
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pending bits re-ordered oldest-first, bit 0 being the queue head.
    always_comb begin
        q_bits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_bits[i] = mem[rd_ptr + PW'(i)];
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/ghr_spec_ctrl.sv
// Speculative / committed global-history controller with in-order mispredict repair.
// Optional mispredict counter port and logic enabled by defining GHR_STATS_EN.
module ghr_spec_ctrl
    import bp_pkg::*;
#(
    parameter int GHR_W = GHR_W_DEF,
    parameter int DEPTH = CKPT_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       br_predF,
    input  logic                       pred_takenF,
    input  logic                       StallF,
    input  logic                       BranchE,
    input  logic                       br_actualE,
    input  logic                       RedirectE,
    output logic [GHR_W-1:0]           ghr_spec,
    output logic [GHR_W-1:0]           ghr_commit,
    output logic                       mispredE,
    output logic                       ckpt_full,
    output logic                       ckpt_empty,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt
`ifdef GHR_STATS_EN
    ,
    output logic [15:0]                mispred_cnt
`endif
);

    logic             push;
    logic             pop;
    logic             recover;
    logic             head_pred;
    logic [DEPTH-1:0] q_bits;
    logic [GHR_W-1:0] commit_next;
    logic [GHR_W-1:0] spec_model;
    logic             hist_sync;

    // Push/pop contract: fetch may push only when not full or when E pops the same
    // cycle; E pops only a non-empty queue; a recovery drops any same-cycle push.
    assign pop         = BranchE & ~ckpt_empty;
    assign mispredE    = pop & (head_pred != br_actualE);
    assign recover     = mispredE | RedirectE;
    assign push        = br_predF & ~StallF & (~ckpt_full | pop) & ~recover;
    assign commit_next = BranchE ? {ghr_commit[GHR_W-2:0], br_actualE} : ghr_commit;

    ghr_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .clear  (recover),
        .din    (pred_takenF),
        .dout   (head_pred),
        .full   (ckpt_full),
        .empty  (ckpt_empty),
        .count  (pend_cnt),
        .q_bits (q_bits)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
        end else begin
            ghr_commit <= commit_next;
            if (recover)   ghr_spec <= commit_next;
            else if (push) ghr_spec <= {ghr_spec[GHR_W-2:0], pred_takenF};
        end
    end

    // An unpaired BranchE shifts only the committed history, so the two histories
    // stay related by the pending bits only until that happens; a recovery realigns them.
    always_ff @(posedge clk) begin
        if (!reset || recover)          hist_sync <= 1'b1;
        else if (BranchE && ckpt_empty) hist_sync <= 1'b0;
    end

    always_comb begin
        spec_model = ghr_commit;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(pend_cnt)) spec_model = {spec_model[GHR_W-2:0], q_bits[i]};
        end
    end

    a_hist_invariant: assert property (@(posedge clk) disable iff (!reset)
        (hist_sync -> (ghr_spec == spec_model)));

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset)
        (int'(pend_cnt) <= DEPTH));

`ifdef GHR_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)                                mispred_cnt <= '0;
        else if (mispredE && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Directed self-checking bench for ghr_spec_ctrl (stats checks only with GHR_STATS_EN).
module tb_ghr_spec_ctrl;
    import bp_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       br_predF, pred_takenF, StallF, BranchE, br_actualE, RedirectE;
    ghr_t       ghr_spec, ghr_commit;
    logic       mispredE, ckpt_full, ckpt_empty;
    logic [2:0] pend_cnt;
`ifdef GHR_STATS_EN
    logic [15:0] mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Bench-side model used by the wrap test.
    ghr_t exp_spec, exp_commit;
    logic exp_q[$];

    ghr_spec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .br_predF    (br_predF),
        .pred_takenF (pred_takenF),
        .StallF      (StallF),
        .BranchE     (BranchE),
        .br_actualE  (br_actualE),
        .RedirectE   (RedirectE),
        .ghr_spec    (ghr_spec),
        .ghr_commit  (ghr_commit),
        .mispredE    (mispredE),
        .ckpt_full   (ckpt_full),
        .ckpt_empty  (ckpt_empty),
        .pend_cnt    (pend_cnt)
`ifdef GHR_STATS_EN
        ,
        .mispred_cnt (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_predF = 0; pred_takenF = 0; StallF = 0;
        BranchE = 0; br_actualE = 0; RedirectE = 0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    task automatic push_bit(input logic b);
        idle();
        br_predF = 1; pred_takenF = b;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        reset = 0;
        br_predF = 1; pred_takenF = 1; BranchE = 1; br_actualE = 1; RedirectE = 0; StallF = 0;
        cycle();
        cycle();
        checks++; if (ghr_spec !== 10'd0) begin errors++; $display("FAIL reset_spec got=%b exp=%b", ghr_spec, 10'd0); end
        checks++; if (ghr_commit !== 10'd0) begin errors++; $display("FAIL reset_commit got=%b exp=%b", ghr_commit, 10'd0); end
        checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", ckpt_empty); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
        idle();
        reset = 1;
        cycle();
    endtask

    task automatic test_correct_pred();
        logic [2:0] dirs;
        apply_reset();
        push_bit(1); push_bit(0); push_bit(1);
        checks++; if (ghr_spec !== 10'b101) begin errors++; $display("FAIL cp_spec got=%b exp=%b", ghr_spec, 10'b101); end
        checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL cp_pend got=%0d exp=3", pend_cnt); end
        checks++; if (ghr_commit !== 10'd0) begin errors++; $display("FAIL cp_commit_pre got=%b exp=0", ghr_commit); end
        dirs = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            BranchE = 1; br_actualE = dirs[i];
            #1;
            checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL cp_mispred[%0d] got=%b exp=0", i, mispredE); end
            cycle();
            idle();
        end
        checks++; if (ghr_commit !== 10'b101) begin errors++; $display("FAIL cp_commit got=%b exp=%b", ghr_commit, 10'b101); end
        checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL cp_empty got=%b exp=1", ckpt_empty); end
        checks++; if (ghr_spec !== 10'b101) begin errors++; $display("FAIL cp_spec_post got=%b exp=%b", ghr_spec, 10'b101); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        push_bit(1); push_bit(1); push_bit(1);
        checks++; if (ghr_spec !== 10'b111) begin errors++; $display("FAIL mp_spec_pre got=%b exp=%b", ghr_spec, 10'b111); end
        BranchE = 1; br_actualE = 0;
        #1;
        checks++; if (mispredE !== 1'b1) begin errors++; $display("FAIL mp_flag got=%b exp=1", mispredE); end
        cycle();
        idle();
        checks++; if (ghr_spec !== 10'd0) begin errors++; $display("FAIL mp_spec got=%b exp=0", ghr_spec); end
        checks++; if (ghr_commit !== 10'd0) begin errors++; $display("FAIL mp_commit got=%b exp=0", ghr_commit); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL mp_pend got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_full_wrap();
        logic [7:0] pat;
        logic       a;
        apply_reset();
        exp_q.delete();
        push_bit(1); push_bit(0); push_bit(1); push_bit(1);
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL fw_full got=%b exp=1", ckpt_full); end
        checks++; if (ghr_spec !== 10'b1011) begin errors++; $display("FAIL fw_spec got=%b exp=%b", ghr_spec, 10'b1011); end
        push_bit(1);
        checks++; if (ghr_spec !== 10'b1011) begin errors++; $display("FAIL fw_drop_spec got=%b exp=%b", ghr_spec, 10'b1011); end
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL fw_drop_pend got=%0d exp=4", pend_cnt); end
        exp_spec = 10'b1011; exp_commit = 10'd0;
        // one push+pop at full, then eight more, crossing the pointer wrap twice
        pat = 8'b0_1001101;
        for (int i = 0; i < 9; i++) begin
            a = exp_q.pop_front();
            br_predF = 1; pred_takenF = pat[i % 8]; BranchE = 1; br_actualE = a;
            #1;
            checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL fw_pp_mispred[%0d] got=%b exp=0", i, mispredE); end
            cycle();
            exp_q.push_back(pat[i % 8]);
            exp_spec = {exp_spec[8:0], pat[i % 8]};
            exp_commit = {exp_commit[8:0], a};
            idle();
            checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL fw_pp_pend[%0d] got=%0d exp=4", i, pend_cnt); end
            checks++; if (ghr_spec !== exp_spec) begin errors++; $display("FAIL fw_pp_spec[%0d] got=%b exp=%b", i, ghr_spec, exp_spec); end
        end
        for (int i = 0; i < 4; i++) begin
            a = exp_q.pop_front();
            BranchE = 1; br_actualE = a;
            #1;
            checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL fw_drain_mispred[%0d] got=%b exp=0", i, mispredE); end
            cycle();
            exp_commit = {exp_commit[8:0], a};
            idle();
        end
        checks++; if (ghr_commit !== exp_commit) begin errors++; $display("FAIL fw_commit got=%b exp=%b", ghr_commit, exp_commit); end
        checks++; if (ghr_spec !== exp_spec) begin errors++; $display("FAIL fw_spec_end got=%b exp=%b", ghr_spec, exp_spec); end
        checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL fw_empty got=%b exp=1", ckpt_empty); end
    endtask

    task automatic test_simultaneous();
        // mispredict with same-cycle push
        apply_reset();
        push_bit(1); push_bit(1);
        BranchE = 1; br_actualE = 0; br_predF = 1; pred_takenF = 1;
        #1;
        checks++; if (mispredE !== 1'b1) begin errors++; $display("FAIL sim_mp_flag got=%b exp=1", mispredE); end
        cycle();
        idle();
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL sim_mp_pend got=%0d exp=0", pend_cnt); end
        checks++; if (ghr_spec !== 10'd0) begin errors++; $display("FAIL sim_mp_spec got=%b exp=0", ghr_spec); end
        // redirect with a correct branch resolution
        push_bit(1); push_bit(0);
        checks++; if (ghr_spec !== 10'b10) begin errors++; $display("FAIL sim_rd_pre got=%b exp=%b", ghr_spec, 10'b10); end
        BranchE = 1; br_actualE = 1; RedirectE = 1;
        #1;
        checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL sim_rd_flag got=%b exp=0", mispredE); end
        cycle();
        idle();
        checks++; if (ghr_spec !== 10'b1) begin errors++; $display("FAIL sim_rd_spec got=%b exp=%b", ghr_spec, 10'b1); end
        checks++; if (ghr_commit !== 10'b1) begin errors++; $display("FAIL sim_rd_commit got=%b exp=%b", ghr_commit, 10'b1); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL sim_rd_pend got=%0d exp=0", pend_cnt); end
        // stalled fetch does not push
        br_predF = 1; pred_takenF = 1; StallF = 1;
        cycle();
        idle();
        checks++; if (ghr_spec !== 10'b1) begin errors++; $display("FAIL sim_stall_spec got=%b exp=%b", ghr_spec, 10'b1); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL sim_stall_pend got=%0d exp=0", pend_cnt); end
        // branch resolving with an empty queue updates only the committed history
        BranchE = 1; br_actualE = 1;
        #1;
        checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL sim_empty_flag got=%b exp=0", mispredE); end
        cycle();
        idle();
        checks++; if (ghr_commit !== 10'b11) begin errors++; $display("FAIL sim_empty_commit got=%b exp=%b", ghr_commit, 10'b11); end
        checks++; if (ghr_spec !== 10'b1) begin errors++; $display("FAIL sim_empty_spec got=%b exp=%b", ghr_spec, 10'b1); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL sim_empty_pend got=%0d exp=0", pend_cnt); end
    endtask

`ifdef GHR_STATS_EN
    task automatic test_stats();
        apply_reset();
        checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL st_reset got=%0d exp=0", mispred_cnt); end
        for (int i = 0; i < 3; i++) begin
            push_bit(1);
            BranchE = 1; br_actualE = 0;
            cycle();
            idle();
        end
        checks++; if (mispred_cnt !== 16'd3) begin errors++; $display("FAIL st_count got=%0d exp=3", mispred_cnt); end
        force dut.mispred_cnt = 16'hFFFF;
        cycle();
        release dut.mispred_cnt;
        push_bit(1);
        BranchE = 1; br_actualE = 0;
        cycle();
        idle();
        checks++; if (mispred_cnt !== 16'hFFFF) begin errors++; $display("FAIL st_sat got=%h exp=ffff", mispred_cnt); end
    endtask
`endif

    initial begin
        idle();
        reset = 0;
        #1;
        test_reset();
        test_correct_pred();
        test_mispredict();
        test_full_wrap();
        test_simultaneous();
`ifdef GHR_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
